// File: rtl/vc32_mem_pkg.sv
// Shared definitions for the quad-SPI PSRAM line-transfer sequencer.
// Holds the FSM state type, the PSRAM command bytes and the bus phase lengths.
package vc32_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StGap
    } state_e;

    localparam logic [7:0]  CMD_READ     = 8'hEB;
    localparam logic [7:0]  CMD_WRITE    = 8'h38;
    localparam int unsigned CMD_NIBBLES  = 2;
    localparam int unsigned ADDR_NIBBLES = 6;

endpackage

// File: rtl/dcache_qspi.sv
// Runs one quad-SPI transaction per cache request: a dirty-line writeback or a line fill.
// Nibbles move high-first; cache strobes are contiguous so the cache offset never splits.
module dcache_qspi
    import vc32_mem_pkg::*;
#(
    parameter int unsigned LINE_LENGTH = 4,
    parameter int unsigned PA          = 22,
    parameter int unsigned DUMMY       = 6,
    parameter int unsigned CS_GAP      = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req,
    input  logic                              push,
    input  logic                              pull,
    input  logic [PA-1:$clog2(LINE_LENGTH)]   tag,
    input  logic [3:0]                        dwrite,
    output logic                              rstrobe_d,
    output logic [3:0]                        dread,
    output logic                              wstrobe_d,
    output logic                              busy,
    output logic                              mem_cs_n,
    output logic                              mem_oe,
    output logic [3:0]                        mem_dout,
    input  logic [3:0]                        mem_din
);

    localparam int unsigned OffW      = $clog2(LINE_LENGTH);
    localparam int unsigned DataBeats = 2 * LINE_LENGTH;
    localparam int unsigned CntW      = $clog2(DataBeats + 16);

    localparam logic [CntW-1:0] CmdLoad   = CntW'(CMD_NIBBLES - 1);
    localparam logic [CntW-1:0] AddrLoad  = CntW'(ADDR_NIBBLES - 1);
    localparam logic [CntW-1:0] DummyLoad = CntW'(DUMMY - 1);
    localparam logic [CntW-1:0] DataLoad  = CntW'(DataBeats - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(CS_GAP - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PA-1:OffW]        tag_q, tag_d;
    logic                    write_q, write_d;
    logic [3:0]              wdata_q;
    logic [3:0]              dread_q;
    logic                    wstrobe_q;

    logic [7:0]              cmd;
    logic [PA-1:0]           line_addr;
    logic [23:0]             byte_addr;
    logic [23:0]             addr_sh;

    // State register plus the small datapath registers tied to the bus phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tag_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            dread_q   <= '0;
            wstrobe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            write_q   <= write_d;
            wstrobe_q <= (state_q == StData) && !write_q;
            if (rstrobe_d) begin
                wdata_q <= dwrite;
            end
            if ((state_q == StData) && !write_q) begin
                dread_q <= mem_din;
            end
        end
    end

    // Next state; the single down-counter is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CntW'(1);
        tag_d   = tag_q;
        write_d = write_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = cnt_q;
                if (req && (push || pull)) begin
                    state_d = StCmd;
                    cnt_d   = CmdLoad;
                    tag_d   = tag;
                    write_d = push;
                end
            end
            StCmd: begin
                if (cnt_q == '0) begin
                    state_d = StAddr;
                    cnt_d   = AddrLoad;
                end
            end
            StAddr: begin
                if (cnt_q == '0) begin
                    state_d = write_q ? StData : StDummy;
                    cnt_d   = write_q ? DataLoad : DummyLoad;
                end
            end
            StDummy: begin
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = DataLoad;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        line_addr           = '0;
        line_addr[PA-1:OffW] = tag_q;
        byte_addr           = 24'(line_addr);
        addr_sh             = byte_addr >> (4 * cnt_q);
        cmd                 = write_q ? CMD_WRITE : CMD_READ;
    end

    // Outputs decode from state; the write strobe leads the bus by one cycle.
    always_comb begin
        mem_cs_n  = 1'b1;
        mem_oe    = 1'b0;
        mem_dout  = '0;
        rstrobe_d = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StCmd: begin
                mem_cs_n = 1'b0;
                mem_oe   = 1'b1;
                mem_dout = cnt_q[0] ? cmd[7:4] : cmd[3:0];
            end
            StAddr: begin
                mem_cs_n  = 1'b0;
                mem_oe    = 1'b1;
                mem_dout  = addr_sh[3:0];
                rstrobe_d = write_q && (cnt_q == '0);
            end
            StDummy: begin
                mem_cs_n = 1'b0;
            end
            StData: begin
                mem_cs_n  = 1'b0;
                mem_oe    = write_q;
                mem_dout  = write_q ? wdata_q : 4'h0;
                rstrobe_d = write_q && (cnt_q != '0);
            end
            default: begin
            end
        endcase
    end

    assign dread     = dread_q;
    assign wstrobe_d = wstrobe_q;

endmodule

// File: tb/tb_dcache_qspi.sv
// Directed bench for dcache_qspi: default instance plus an LINE_LENGTH=8/DUMMY=1/CS_GAP=3 one.
// A PSRAM model returns read data; a cache model feeds writeback nibbles off rstrobe_d.
module tb_dcache_qspi;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, push, pull;
    logic [21:2] tag;
    logic [21:3] tag8;
    logic [3:0]  dwrite, mem_din;

    logic       rs_a, ws_a, busy_a, cs_a, oe_a;
    logic [3:0] dread_a, dout_a;
    logic       rs_b, ws_b, busy_b, cs_b, oe_b;
    logic [3:0] dread_b, dout_b;

    always #5 clk = ~clk;

    dcache_qspi dut (
        .clk(clk), .reset(reset), .req(req), .push(push), .pull(pull), .tag(tag),
        .dwrite(dwrite), .rstrobe_d(rs_a), .dread(dread_a), .wstrobe_d(ws_a), .busy(busy_a),
        .mem_cs_n(cs_a), .mem_oe(oe_a), .mem_dout(dout_a), .mem_din(mem_din)
    );

    dcache_qspi #(.LINE_LENGTH(8), .PA(22), .DUMMY(1), .CS_GAP(3)) dut8 (
        .clk(clk), .reset(reset), .req(req), .push(push), .pull(pull), .tag(tag8),
        .dwrite(dwrite), .rstrobe_d(rs_b), .dread(dread_b), .wstrobe_d(ws_b), .busy(busy_b),
        .mem_cs_n(cs_b), .mem_oe(oe_b), .mem_dout(dout_b), .mem_din(mem_din)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc, ti, woff, dm, ll;
    logic       sel;
    logic [7:0] mcmd;
    logic [3:0] wline [16];

    logic       cs_log [64];
    logic       oe_log [64];
    logic       busy_log [64];
    logic       rs_log [64];
    logic       ws_log [64];
    logic [3:0] dout_log [64];
    logic [3:0] dread_log [64];

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 1'b0; push = 1'b0; pull = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0; ti = 0; woff = 0; mcmd = '0; mem_din = '0; dwrite = '0;
    endtask

    // Log the selected DUT for this cycle, run the memory and cache models, advance one clock.
    task automatic step();
        logic       o_cs, o_oe, o_busy, o_rs, o_ws;
        logic [3:0] o_dout, o_dread;
        o_cs    = sel ? cs_b    : cs_a;
        o_oe    = sel ? oe_b    : oe_a;
        o_busy  = sel ? busy_b  : busy_a;
        o_rs    = sel ? rs_b    : rs_a;
        o_ws    = sel ? ws_b    : ws_a;
        o_dout  = sel ? dout_b  : dout_a;
        o_dread = sel ? dread_b : dread_a;
        dm = sel ? 1 : 6;
        ll = sel ? 8 : 4;
        cs_log[cyc] = o_cs; oe_log[cyc] = o_oe; busy_log[cyc] = o_busy;
        rs_log[cyc] = o_rs; ws_log[cyc] = o_ws;
        dout_log[cyc] = o_dout; dread_log[cyc] = o_dread;
        if (!o_cs) ti++;
        else ti = 0;
        if (ti == 1) mcmd[7:4] = o_dout;
        if (ti == 2) mcmd[3:0] = o_dout;
        mem_din = '0;
        if (mcmd == 8'hEB && ti >= 9 + dm && ti < 9 + dm + 2 * ll) mem_din = 4'(ti - 8 - dm);
        if (o_rs) begin
            dwrite = wline[woff % 16];
            woff++;
        end else begin
            woff = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int count_ones(input int first, input int last, input bit use_ws);
        int n = 0;
        for (int i = first; i <= last; i++) n += use_ws ? int'(ws_log[i]) : int'(rs_log[i]);
        return n;
    endfunction

    initial begin
        sel = 1'b0;
        tag = '0;
        tag8 = '0;
        dwrite = '0;
        mem_din = '0;
        for (int i = 0; i < 16; i++) wline[i] = 4'(i + 3);

        // Read fill, tag 0x12345 -> byte address 0x048D14.
        do_reset();
        tag = 20'h12345;
        req = 1'b1; pull = 1'b1;
        while (cyc < 30) begin
            if (cyc == 10) req = 1'b0;
            step();
        end
        check_eq("rst_cs_n", 32'(cs_log[0]), 1);
        check_eq("rst_busy", 32'(busy_log[0]), 0);
        check_eq("rst_oe", 32'(oe_log[0]), 0);
        check_eq("rst_dout", 32'(dout_log[0]), 0);
        check_eq("rst_dread", 32'(dread_log[0]), 0);
        check_eq("rst_strobes", 32'({ws_log[0], rs_log[0]}), 0);
        check_eq("rd_cs_fall", 32'(cs_log[1]), 0);
        check_eq("rd_busy_rise", 32'(busy_log[1]), 1);
        check_eq("rd_cmd_hi", 32'(dout_log[1]), 32'hE);
        check_eq("rd_cmd_lo", 32'(dout_log[2]), 32'hB);
        check_eq("rd_addr", {8'h0, dout_log[3], dout_log[4], dout_log[5], dout_log[6],
                             dout_log[7], dout_log[8]}, 32'h048D14);
        check_eq("rd_oe_addr", 32'(oe_log[8]), 1);
        check_eq("rd_oe_dummy", 32'(oe_log[9]), 0);
        check_eq("rd_ws_before", 32'(ws_log[15]), 0);
        check_eq("rd_ws_count", 32'(count_ones(16, 23, 1'b1)), 8);
        check_eq("rd_ws_after", 32'(ws_log[24]), 0);
        for (int k = 0; k < 8; k++) check_eq($sformatf("rd_dread%0d", k),
                                             32'(dread_log[16 + k]), 32'(k + 1));
        check_eq("rd_gap_cs", 32'(cs_log[23]), 1);
        check_eq("rd_gap_busy", 32'(busy_log[23]), 1);
        check_eq("rd_idle_busy", 32'(busy_log[24]), 0);

        // Writeback of A..F,3,5 then a fill once the cache flips push to pull.
        wline[0] = 4'hA; wline[1] = 4'hB; wline[2] = 4'hC; wline[3] = 4'hD;
        wline[4] = 4'hE; wline[5] = 4'hF; wline[6] = 4'h3; wline[7] = 4'h5;
        do_reset();
        tag = 20'h00ABC;
        req = 1'b1; push = 1'b1;
        while (cyc < 50) begin
            if (cyc == 12) begin
                push = 1'b0;
                pull = 1'b1;
            end
            if (cyc == 30) req = 1'b0;
            step();
        end
        check_eq("wb_cmd", {24'h0, dout_log[1], dout_log[2]}, 32'h38);
        check_eq("wb_rs_before", 32'(rs_log[7]), 0);
        check_eq("wb_rs_count", 32'(count_ones(8, 15, 1'b0)), 8);
        check_eq("wb_rs_after", 32'(rs_log[16]), 0);
        for (int k = 0; k < 8; k++) check_eq($sformatf("wb_bus%0d", k),
                                             32'(dout_log[9 + k]), 32'(wline[k]));
        check_eq("wb_oe_data", 32'(oe_log[16]), 1);
        check_eq("wb_gap_cs", 32'(cs_log[17]), 1);
        check_eq("wb_gap_busy", 32'(busy_log[17]), 1);
        check_eq("wb_idle_busy", 32'(busy_log[18]), 0);
        check_eq("wb_fill_cs", 32'(cs_log[19]), 0);
        check_eq("wb_fill_cmd", {24'h0, dout_log[19], dout_log[20]}, 32'hEB);
        check_eq("wb_fill_ws_pre", 32'(ws_log[33]), 0);
        check_eq("wb_fill_ws_count", 32'(count_ones(34, 41, 1'b1)), 8);
        check_eq("wb_fill_first", 32'(dread_log[34]), 1);
        check_eq("wb_fill_last", 32'(dread_log[41]), 8);
        check_eq("wb_fill_done", 32'(busy_log[42]), 0);

        // push and pull together, req withdrawn at cycle 5; top-of-range tag.
        do_reset();
        tag = 20'hFFFFF;
        req = 1'b1; push = 1'b1; pull = 1'b1;
        while (cyc < 30) begin
            if (cyc == 5) req = 1'b0;
            step();
        end
        check_eq("pri_cmd", {24'h0, dout_log[1], dout_log[2]}, 32'h38);
        check_eq("pri_addr_hi", 32'(dout_log[3]), 32'h3);
        check_eq("pri_addr_lo", 32'(dout_log[8]), 32'hC);
        check_eq("wd_rs_total", 32'(count_ones(0, 29, 1'b0)), 8);
        check_eq("wd_gap_busy", 32'(busy_log[17]), 1);
        check_eq("wd_idle_busy", 32'(busy_log[18]), 0);
        check_eq("wd_no_relaunch", 32'(cs_log[19]), 1);

        // Reset during read DATA at cycle 18, then relaunch.
        do_reset();
        tag = 20'h12345;
        req = 1'b1; pull = 1'b1;
        while (cyc < 30) begin
            if (cyc == 18) reset = 1'b1;
            if (cyc == 19) reset = 1'b0;
            step();
        end
        check_eq("mr_ws_live", 32'(ws_log[18]), 1);
        check_eq("mr_ws_drop", 32'(ws_log[19]), 0);
        check_eq("mr_cs", 32'(cs_log[19]), 1);
        check_eq("mr_busy", 32'(busy_log[19]), 0);
        check_eq("mr_dread", 32'(dread_log[19]), 0);
        check_eq("mr_restart_cs", 32'(cs_log[20]), 0);
        check_eq("mr_restart_cmd", {24'h0, dout_log[20], dout_log[21]}, 32'hEB);

        // LINE_LENGTH=8, CS_GAP=3 instance: back-to-back writes with push held.
        for (int i = 0; i < 16; i++) wline[i] = 4'(15 - i);
        sel = 1'b1;
        do_reset();
        tag8 = 19'h2A5A5;
        req = 1'b1; push = 1'b1;
        while (cyc < 35) step();
        check_eq("p8_rs_before", 32'(rs_log[7]), 0);
        check_eq("p8_rs_count", 32'(count_ones(8, 23, 1'b0)), 16);
        check_eq("p8_rs_after", 32'(rs_log[24]), 0);
        check_eq("p8_bus_first", 32'(dout_log[9]), 32'(wline[0]));
        check_eq("p8_bus_last", 32'(dout_log[24]), 32'(wline[15]));
        check_eq("p8_data_cs", 32'(cs_log[24]), 0);
        check_eq("p8_gap_cs", {29'h0, cs_log[25], cs_log[26], cs_log[27]}, 32'h7);
        check_eq("p8_gap_busy", 32'(busy_log[27]), 1);
        check_eq("p8_idle_busy", 32'(busy_log[28]), 0);
        check_eq("p8_relaunch", 32'(cs_log[29]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_qspi.md
# dcache_qspi

Nibble-serial line-transfer sequencer between the data cache and an external quad-SPI PSRAM. It watches the cache's miss outputs (`push`, `pull`, `tag`). For each request it runs exactly one transaction on the 4-bit memory bus: a writeback of a dirty line or a fill of a missing line. It drives the cache's `wstrobe_d`/`dread` fill port and `rstrobe_d`/`dwrite` writeback port in the contiguous, high-nibble-first order the cache expects.

## Interface
Parameters:
- `LINE_LENGTH`, 4: cache line bytes; the data phase is 2*LINE_LENGTH nibbles.
- `PA`, 22: physical address width; `tag` is `[PA-1:$clog2(LINE_LENGTH)]`.
- `DUMMY`, 6: read dummy cycles, 1..15.
- `CS_GAP`, 1: minimum deselected cycles between transactions, 1..7.

Ports:
- `clk`  in  1  clock. One clock domain.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  cache has a pending access that missed or needs writeback.
- `push`  in  1  cache wants a dirty line written.
- `pull`  in  1  cache wants a line read.
- `tag`  in  PA-log2(LL)  line address from the cache.
- `dwrite`  in  4  writeback nibble from the cache.
- `rstrobe_d`  out  1  cache writeback strobe.
- `dread`  out  4  fill nibble to the cache.
- `wstrobe_d`  out  1  cache fill strobe.
- `busy`  out  1  transaction in progress, including the gap state.
- `mem_cs_n`  out  1  memory chip select, active low.
- `mem_oe`  out  1  1 means this block drives `mem_dout`.
- `mem_dout`  out  4  nibble to memory.
- `mem_din`  in  4  nibble from memory.

## Operation
- States: IDLE, CMD (2 cycles), ADDR (6), DUMMY (`DUMMY` cycles, reads only), DATA (2*LINE_LENGTH), GAP (`CS_GAP`). A single down-counter is reloaded on each state entry.
- Transaction selection in IDLE:
  - `req&&push`: write transaction, command 0x38.
  - `req&&!push&&pull`: read transaction, command 0xEB.
  - `push` takes priority.
  - `tag` and the transaction type are latched on leaving IDLE and held to GAP.
- Address: 24-bit byte address `{zero-extend(tag), log2(LINE_LENGTH) zeros}`, sent MSB nibble first. The command is also sent MSB nibble first.
- Write transaction:
  - `mem_oe=1` through CMD, ADDR and DATA. There is no DUMMY.
  - `rstrobe_d` is high for exactly 2*LINE_LENGTH contiguous cycles, starting in the last ADDR cycle.
  - `mem_dout` registers `dwrite` each such cycle, so the memory sees nibble k in DATA cycle k.
- Read transaction:
  - `mem_oe=1` in CMD and ADDR, 0 from the first DUMMY cycle onward.
  - `mem_din` is sampled every DATA cycle into the `dread` register. `wstrobe_d` is registered alongside it, giving 2*LINE_LENGTH contiguous cycles delayed by one.
- Strobes are never split. The cache resets its nibble offset whenever the strobe drops.
- After DATA comes GAP with `mem_cs_n=1`, then IDLE, which resamples `req`. A writeback is therefore followed by a fresh decision. Normally the cache now shows `pull`; after a flush-write it shows neither.
- `req`, `push`, `pull` and `tag` changing after launch are ignored. The cache holds its address stable until its line completes.

## Timing
- Reset values: `mem_cs_n=1`, `mem_oe=0`, `mem_dout=0`, `dread=0`, `wstrobe_d=0`, `rstrobe_d=0`, `busy=0`. State is IDLE.
- Reset asserted mid-transaction:
  - All of the above take effect at the next edge.
  - A partially delivered strobe burst is abandoned. The cache's offset restarts from 0 when the strobe drops.
- Timeline, with IDLE seeing `req` at cycle 0:
  - `mem_cs_n` falls and `busy` rises at cycle 1.
  - CMD at 1-2, ADDR at 3-8.
- Read, LINE_LENGTH=4, DUMMY=6: DUMMY at 9-14, DATA at 15-22, `wstrobe_d` at 16-23, GAP at 23, IDLE at 24.
- Write, LINE_LENGTH=4: `rstrobe_d` at 8-15, DATA on the bus at 9-16, GAP at 17, IDLE at 18.
- `busy` is high from cycle 1 through the last GAP cycle.
- Minimum cycle from IDLE back to `mem_cs_n` low is 2: one IDLE cycle plus the next launch.

## Structure
- Shared package `vc32_mem_pkg`:
  - state enum
  - command constants `CMD_READ=8'hEB`, `CMD_WRITE=8'h38`
  - `ADDR_NIBBLES=6`
- Single module with no sub-module. The counter and shift mux are small enough to inline.

## Test plan
- Read fill:
  - Stimulus: `req=pull=1`, `tag=20'h12345`, memory returns nibbles 1..8.
  - Response:
    - address nibbles `0,4,8,D,1,4`
    - `wstrobe_d` high at cycles 16-23
    - `dread` sequence 1..8
    - `busy` clear at cycle 24.
- Writeback then fill:
  - Stimulus: `req=push=1`, `dwrite` sequence A..H, model cache drops `push` and raises `pull`.
  - Response: bus data A..H on cycles 9-16, command 0x38, then GAP, then a read transaction with 0xEB starting 2 cycles later.
- Priority: `push=pull=1` yields a write transaction first.
- Request withdrawn: dropping `req` at cycle 5 does not shorten the transaction; exactly 8 strobes are delivered.
- Reset at read cycle 18: `wstrobe_d` is 0 on the next edge, `mem_cs_n=1`, state IDLE; the following request restarts from CMD.
- Parameters LINE_LENGTH=8, DUMMY=1, CS_GAP=3: 16 contiguous strobes and a 3-cycle deselect are observed.
